// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command codes and the state
// encodings of the receive-side and transmit-side controllers.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   typedef enum logic [3:0] {
      RX_IDLE      = 4'd0,
      RX_WR_ADDR   = 4'd1,
      RX_WR_DATA   = 4'd2,
      RX_RD_ADDR   = 4'd3,
      RX_RD_WAIT   = 4'd4,
      RX_OPA       = 4'd5,
      RX_OPB       = 4'd6,
      RX_ALU_FUN_S = 4'd7,
      RX_ALU_GO    = 4'd8,
      RX_ALU_WAIT  = 4'd9
   } rx_state_e;

   // Transmit-side controller states, kept here so both halves share one place.
   typedef enum logic [2:0] {
      TX_IDLE     = 3'd0,
      TX_RD_DATA  = 3'd1,
      TX_ALU_LSB  = 3'd2,
      TX_ALU_MSB  = 3'd3
   } tx_state_e;

   // Observable FSM view of the receive controller.
   typedef struct packed {
      rx_state_e state;
      logic      busy;
   } rx_dbg_t;

endpackage

// File: rtl/sys_ctrl_rx.sv
// Receive-side command decoder: parses UART bytes into register-file
// write/read strobes and ALU launches, then waits for the result.
module sys_ctrl_rx
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4,
   parameter int OPA_ADDR   = 0,
   parameter int OPB_ADDR   = 1
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic                  Rd_data_valid,
   input  logic                  ALU_OUT_valid,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   output logic                  ALU_EN,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  CLK_GATE_EN,
   output logic                  Busy,
   output logic                  Cmd_Err,
   output logic                  Drop
);

   localparam logic [DATA_WIDTH-1:0] CODE_WR  = DATA_WIDTH'(CMD_RF_WR);
   localparam logic [DATA_WIDTH-1:0] CODE_RD  = DATA_WIDTH'(CMD_RF_RD);
   localparam logic [DATA_WIDTH-1:0] CODE_OP  = DATA_WIDTH'(CMD_ALU_OP);
   localparam logic [DATA_WIDTH-1:0] CODE_NOP = DATA_WIDTH'(CMD_ALU_NOP);
   localparam logic [ADDR_WIDTH-1:0] A_ADDR   = ADDR_WIDTH'(OPA_ADDR);
   localparam logic [ADDR_WIDTH-1:0] B_ADDR   = ADDR_WIDTH'(OPB_ADDR);

   // RX_D_VLD is a one-cycle qualifier with no backpressure: every byte seen
   // with RX_D_VLD high is consumed in that cycle, either parsed by the
   // current state or discarded with a Drop pulse while a result is awaited.

   rx_state_e               state_q, state_d;
   logic                    busy_q, busy_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [FUN_WIDTH-1:0]    fun_q, fun_d;
   logic                    wr_en_q, wr_en_d;
   logic                    rd_en_q, rd_en_d;
   logic                    alu_en_q, alu_en_d;
   logic                    gate_q, gate_d;
   logic                    err_q, err_d;
   logic                    drop_q, drop_d;
   rx_dbg_t                 dbg;

   assign dbg = '{state: state_q, busy: busy_q};

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RX_IDLE;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         fun_q    <= '0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         alu_en_q <= 1'b0;
         gate_q   <= 1'b0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fun_q    <= fun_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         alu_en_q <= alu_en_d;
         gate_q   <= gate_d;
         err_q    <= err_d;
         drop_q   <= drop_d;
      end
   end

   // Next-state and next-output logic; every output is registered above.
   always_comb begin
      state_d  = dbg.state;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      fun_d    = fun_q;
      gate_d   = gate_q;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;
      alu_en_d = 1'b0;
      err_d    = 1'b0;
      drop_d   = 1'b0;

      case (dbg.state)
         RX_IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CODE_WR)       state_d = RX_WR_ADDR;
               else if (RX_P_DATA == CODE_RD)  state_d = RX_RD_ADDR;
               else if (RX_P_DATA == CODE_OP)  state_d = RX_OPA;
               else if (RX_P_DATA == CODE_NOP) state_d = RX_ALU_FUN_S;
               else                            err_d   = 1'b1;
            end
         end
         RX_WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = RX_WR_DATA;
            end
         end
         RX_WR_DATA: begin
            if (RX_D_VLD) begin
               wdata_d = RX_P_DATA;
               wr_en_d = 1'b1;
               state_d = RX_IDLE;
            end
         end
         RX_RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_d = 1'b1;
               state_d = RX_RD_WAIT;
            end
         end
         RX_RD_WAIT: begin
            drop_d = RX_D_VLD;
            if (Rd_data_valid) state_d = RX_IDLE;
         end
         RX_OPA: begin
            if (RX_D_VLD) begin
               addr_d  = A_ADDR;
               wdata_d = RX_P_DATA;
               wr_en_d = 1'b1;
               state_d = RX_OPB;
            end
         end
         RX_OPB: begin
            if (RX_D_VLD) begin
               addr_d  = B_ADDR;
               wdata_d = RX_P_DATA;
               wr_en_d = 1'b1;
               state_d = RX_ALU_FUN_S;
            end
         end
         RX_ALU_FUN_S: begin
            if (RX_D_VLD) begin
               fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
               gate_d  = 1'b1;
               state_d = RX_ALU_GO;
            end
         end
         RX_ALU_GO: begin
            // Gate was opened last cycle, so the ALU clock runs before launch.
            drop_d   = RX_D_VLD;
            alu_en_d = 1'b1;
            state_d  = RX_ALU_WAIT;
         end
         RX_ALU_WAIT: begin
            drop_d = RX_D_VLD;
            if (ALU_OUT_valid) begin
               gate_d  = 1'b0;
               fun_d   = '0;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      busy_d = (state_d != RX_IDLE);
   end

   assign RF_Address  = addr_q;
   assign RF_WrData   = wdata_q;
   assign RF_WrEn     = wr_en_q;
   assign RF_RdEn     = rd_en_q;
   assign ALU_EN      = alu_en_q;
   assign ALU_FUN     = fun_q;
   assign CLK_GATE_EN = gate_q;
   assign Busy        = dbg.busy;
   assign Cmd_Err     = err_q;
   assign Drop        = drop_q;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Testbench for sys_ctrl_rx: directed frames then random frames, each cycle
// compared against a frame-level reference model.
module tb_sys_ctrl_rx;
   import sys_ctrl_pkg::*;

   logic       CLK;
   logic       rst_n;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic       Rd_data_valid;
   logic       ALU_OUT_valid;
   logic [3:0] RF_Address;
   logic       RF_WrEn;
   logic       RF_RdEn;
   logic [7:0] RF_WrData;
   logic       ALU_EN;
   logic [3:0] ALU_FUN;
   logic       CLK_GATE_EN;
   logic       Busy;
   logic       Cmd_Err;
   logic       Drop;

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   sys_ctrl_rx dut (
      .CLK           (CLK),
      .rst_n         (rst_n),
      .RX_P_DATA     (RX_P_DATA),
      .RX_D_VLD      (RX_D_VLD),
      .Rd_data_valid (Rd_data_valid),
      .ALU_OUT_valid (ALU_OUT_valid),
      .RF_Address    (RF_Address),
      .RF_WrEn       (RF_WrEn),
      .RF_RdEn       (RF_RdEn),
      .RF_WrData     (RF_WrData),
      .ALU_EN        (ALU_EN),
      .ALU_FUN       (ALU_FUN),
      .CLK_GATE_EN   (CLK_GATE_EN),
      .Busy          (Busy),
      .Cmd_Err       (Cmd_Err),
      .Drop          (Drop)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // The model keeps the bytes of the frame collected so far and what result
   // (if any) is being awaited: 0 none, 1 read data, 2 ALU launch due, 3 ALU result.
   logic [7:0] frame[$];
   int         awaiting;
   logic [3:0] pend_addr;
   logic       m_wr, m_rd, m_alu_en, m_err, m_drop, m_busy, m_gate;
   logic [3:0] m_addr, m_fun;
   logic [7:0] m_data;

   task automatic model_reset();
      frame.delete();
      awaiting  = 0;
      pend_addr = '0;
      m_wr = 0; m_rd = 0; m_alu_en = 0; m_err = 0; m_drop = 0; m_busy = 0; m_gate = 0;
      m_addr = '0; m_fun = '0; m_data = '0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] b, input logic rv, input logic av);
      m_wr = 0; m_rd = 0; m_alu_en = 0; m_err = 0; m_drop = 0;
      if (awaiting == 1) begin
         m_drop = v;
         if (rv) awaiting = 0;
      end else if (awaiting == 2) begin
         m_drop   = v;
         m_alu_en = 1;
         awaiting = 3;
      end else if (awaiting == 3) begin
         m_drop = v;
         if (av) begin
            awaiting = 0;
            m_gate   = 0;
            m_fun    = '0;
         end
      end else if (v) begin
         frame.push_back(b);
         if (frame.size() == 1) begin
            if (!(b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD)) begin
               m_err = 1;
               frame.delete();
            end
         end else begin
            case (frame[0])
               8'hAA: begin
                  if (frame.size() == 2) pend_addr = b[3:0];
                  else begin
                     m_addr = pend_addr; m_data = b; m_wr = 1;
                     frame.delete();
                  end
               end
               8'hBB: begin
                  m_addr = b[3:0]; m_rd = 1; awaiting = 1;
                  frame.delete();
               end
               8'hCC: begin
                  if (frame.size() == 2) begin
                     m_addr = 4'd0; m_data = b; m_wr = 1;
                  end else if (frame.size() == 3) begin
                     m_addr = 4'd1; m_data = b; m_wr = 1;
                  end else begin
                     m_fun = b[3:0]; m_gate = 1; awaiting = 2;
                     frame.delete();
                  end
               end
               default: begin
                  m_fun = b[3:0]; m_gate = 1; awaiting = 2;
                  frame.delete();
               end
            endcase
         end
      end
      m_busy = (frame.size() != 0) || (awaiting != 0);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("RF_WrEn",     32'(RF_WrEn),     32'(m_wr));
      chk("RF_RdEn",     32'(RF_RdEn),     32'(m_rd));
      chk("ALU_EN",      32'(ALU_EN),      32'(m_alu_en));
      chk("Cmd_Err",     32'(Cmd_Err),     32'(m_err));
      chk("Drop",        32'(Drop),        32'(m_drop));
      chk("Busy",        32'(Busy),        32'(m_busy));
      chk("CLK_GATE_EN", 32'(CLK_GATE_EN), 32'(m_gate));
      if (m_wr || m_rd) chk("RF_Address", 32'(RF_Address), 32'(m_addr));
      if (m_wr)         chk("RF_WrData",  32'(RF_WrData),  32'(m_data));
      if (m_alu_en)     chk("ALU_FUN",    32'(ALU_FUN),    32'(m_fun));
   endtask

   task automatic check_all_zero();
      chk("rst_outputs",
          {16'd0, RF_Address, RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, Busy, Cmd_Err, Drop, ALU_FUN[0]},
          32'd0);
      chk("rst_data", {20'd0, RF_WrData, ALU_FUN}, 32'd0);
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1: drive, wait for the edge, advance model, compare.
   task automatic tick(input logic v, input logic [7:0] b, input logic rv, input logic av);
      RX_D_VLD      = v;
      RX_P_DATA     = b;
      Rd_data_valid = rv;
      ALU_OUT_valid = av;
      @(posedge CLK);
      model_step(v, b, rv, av);
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      tick(1'b1, b, 1'b0, 1'b0);
      repeat (gap) tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic apply_reset(input int n);
      rst_n         = 1'b0;
      RX_D_VLD      = 1'b0;
      RX_P_DATA     = 8'h00;
      Rd_data_valid = 1'b0;
      ALU_OUT_valid = 1'b0;
      model_reset();
      #1;
      check_all_zero();
      repeat (n) begin
         @(posedge CLK);
         #1;
         check_all_zero();
      end
      rst_n = 1'b1;
   endtask

   // Random wait phases: junk bytes may arrive, including with the valid.
   task automatic rd_wait(input int n);
      repeat (n) tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
      tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0);
   endtask

   task automatic alu_wait(input int n);
      repeat (n) tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
      tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n         = 1'b1;
      RX_D_VLD      = 1'b0;
      RX_P_DATA     = 8'h00;
      Rd_data_valid = 1'b0;
      ALU_OUT_valid = 1'b0;
      model_reset();
      #2;
      apply_reset(2);
      idle(2);

      // RF write with one-cycle gaps
      send(8'hAA, 1); send(8'h05, 1); send(8'h3C, 1);
      idle(1);

      // RF read, data valid three cycles after the strobe
      send(8'hBB, 0); send(8'h07, 0);
      idle(2);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);

      // ALU with operands, result four cycles after launch
      send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h02, 0);
      idle(1);
      idle(3);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      idle(2);

      // ALU without operands, stray byte while waiting
      send(8'hDD, 0); send(8'h08, 0);
      idle(1);
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      idle(1);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      idle(1);

      // Unknown command, then a write whose payload looks like commands
      send(8'h77, 0);
      send(8'hAA, 0); send(8'h01, 0); send(8'hFF, 0);
      send(8'hAA, 0); send(8'hBB, 0); send(8'hAA, 0);
      idle(1);

      // Reset in the middle of a frame
      send(8'hAA, 0); send(8'h03, 0);
      apply_reset(2);
      send(8'h09, 0);
      idle(2);

      // Randomized frames
      for (int f = 0; f < 80; f++) begin
         int         kind;
         int         gap;
         logic [7:0] b;
         kind = $urandom_range(0, 4);
         gap  = $urandom_range(0, 2);
         case (kind)
            0: begin
               send(8'hAA, gap); send(8'($urandom), gap); send(8'($urandom), gap);
            end
            1: begin
               send(8'hBB, gap); send(8'($urandom), 0);
               rd_wait($urandom_range(0, 4));
            end
            2: begin
               send(8'hCC, gap); send(8'($urandom), gap); send(8'($urandom), gap);
               send(8'($urandom), 0);
               alu_wait($urandom_range(1, 5));
            end
            3: begin
               send(8'hDD, gap); send(8'($urandom), 0);
               alu_wait($urandom_range(1, 5));
            end
            default: begin
               do b = 8'($urandom);
               while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
               send(b, gap);
            end
         endcase
         idle($urandom_range(0, 2));
         if (f == 40) begin
            send(8'hCC, 0); send(8'($urandom), 0);
            apply_reset(1);
         end
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sys_ctrl_rx.md
Name: sys_ctrl_rx

Overview:
- Command decoder on the receive side of the system controller.
- Consumes parallel bytes from the UART receiver and parses the frame protocol.
- Drives register-file write/read strobes and ALU launch with clock-gate control.
- Waits for the register-file read data or the ALU result to be produced. Those results then flow to the transmit-side controller and out via the TX FIFO.

Parameters:
- DATA_WIDTH, 8, width of UART byte, register-file data, ALU operands.
- ADDR_WIDTH, 4, register-file address width.
- FUN_WIDTH, 4, ALU function code width.
- OPA_ADDR, 0, register-file address of ALU operand A.
- OPB_ADDR, 1, register-file address of ALU operand B.

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  DATA_WIDTH  received byte, valid only when RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- Rd_data_valid  in  1  register-file read data ready (terminates read command).
- ALU_OUT_valid  in  1  ALU result ready (terminates ALU command).
- RF_Address  out  ADDR_WIDTH  register-file address.
- RF_WrEn  out  1  one-cycle write strobe.
- RF_RdEn  out  1  one-cycle read strobe.
- RF_WrData  out  DATA_WIDTH  register-file write data.
- ALU_EN  out  1  one-cycle ALU launch pulse.
- ALU_FUN  out  FUN_WIDTH  ALU function, held from FUN byte until return to IDLE.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- Busy  out  1  high in every state except IDLE.
- Cmd_Err  out  1  one-cycle pulse on unknown command byte.
- Drop  out  1  one-cycle pulse when a byte arrives in RD_WAIT/ALU_WAIT/ALU_GO.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-frame aborts the frame with no partial strobes. First byte after reset is treated as a command.
- All outputs are registered. Strobes appear in the cycle after the RX_D_VLD cycle that triggers them.
- Command codes:
  - 0xAA = RF write: addr byte, then data byte.
  - 0xBB = RF read: addr byte.
  - 0xCC = ALU with operands: A, B, FUN.
  - 0xDD = ALU without operands: FUN.
- Address bytes use the low ADDR_WIDTH bits; upper bits are ignored. FUN bytes use the low FUN_WIDTH bits.
- State transitions (on RX_D_VLD unless noted):
  - IDLE: AA->WR_ADDR, BB->RD_ADDR, CC->OPA, DD->ALU_FUN_S. Any other byte -> stay in IDLE, pulse Cmd_Err.
  - WR_ADDR: latch address -> WR_DATA.
  - WR_DATA: RF_WrData=byte, RF_WrEn pulse -> IDLE.
  - RD_ADDR: RF_Address=byte, RF_RdEn pulse -> RD_WAIT.
  - RD_WAIT: on Rd_data_valid -> IDLE.
  - OPA: RF_Address=OPA_ADDR, RF_WrData=byte, RF_WrEn pulse -> OPB.
  - OPB: same with OPB_ADDR -> ALU_FUN_S.
  - ALU_FUN_S: latch ALU_FUN, CLK_GATE_EN=1 -> ALU_GO.
  - ALU_GO (unconditional, one cycle): ALU_EN pulse -> ALU_WAIT. CLK_GATE_EN therefore leads ALU_EN by one cycle.
  - ALU_WAIT: on ALU_OUT_valid -> IDLE. CLK_GATE_EN falls in the cycle after ALU_OUT_valid.
- Bytes arriving in RD_WAIT, ALU_GO or ALU_WAIT are discarded and pulse Drop; state is unchanged.
- A byte arriving in the same cycle as Rd_data_valid/ALU_OUT_valid is dropped, not taken as a new command.
- Command bytes are not re-interpreted mid-frame: 0xAA as a data byte is data.
- No timeout. A missing Rd_data_valid or ALU_OUT_valid holds the block in the wait state until reset.
- RF_Address and RF_WrData hold their last values between strobes.

Decomposition:
- Shared package sys_ctrl_pkg:
  - command codes CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - the state encoding constants for this block, kept alongside those of the transmit-side controller.
- Single module; no sub-module. Optional reuse: the parallel-byte capture register pattern only.

Test Plan:
- AA,05,3C with 1-cycle gaps -> RF_WrEn single pulse with RF_Address=5 and RF_WrData=3C, 1 cycle after the 3C byte; Busy low the following cycle.
- BB,07 then Rd_data_valid 3 cycles later -> RF_RdEn pulse with RF_Address=7; Busy high until the cycle after Rd_data_valid.
- CC,12,34,02 then ALU_OUT_valid 4 cycles after ALU_EN -> RF_WrEn with (0,12) then (1,34); CLK_GATE_EN rises; ALU_EN with ALU_FUN=2 one cycle later; CLK_GATE_EN falls 1 cycle after ALU_OUT_valid.
- DD,08 -> no RF strobes; ALU_EN with ALU_FUN=8. A byte 0x55 during ALU_WAIT -> Drop pulse, no state change, Cmd_Err stays 0.
- Byte 0x77 in IDLE -> Cmd_Err pulse, stay in IDLE; a following AA,01,FF completes normally.
- AA,03 then rst_n low for 2 cycles, then byte 0x9 -> no RF_WrEn; 0x9 gives Cmd_Err (treated as command); all outputs 0 during reset.
